// File: rtl/fpx_mul_pipe.sv
// Two-stage pipelined minifloat multiplier for any EXP_W/MAN_W format (no Inf/NaN, exact subnormals).
// Stage 1 forms the exact significand product; stage 2 normalises, rounds (RNE or truncate) and saturates.
module fpx_mul_pipe #(
  parameter  int EXP_W = 2,
  parameter  int MAN_W = 1,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_sat,
  output logic         out_inexact
);

  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int ESW  = EXP_W + 2;
  localparam int EXW  = EXP_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;
  localparam int LW   = $clog2(PW) + 1;
  localparam int BEW  = EXP_W + LW + 3;
  localparam int SHW  = $clog2(PW + 2) + 1;
  localparam int TW   = 2 * PW + 2;
  localparam int MGW  = EXW + MAN_W;

  logic en;

  // Stage 1 combinational
  logic [EXP_W-1:0] ea, eb;
  logic [SW-1:0]    sig_a, sig_b;
  logic [ESW-1:0]   eeff_a, eeff_b;
  logic [PW-1:0]    prod_d;
  logic [ESW-1:0]   esum_d;
  logic             zero_d, sign_d;

  // Stage 1 registers
  logic             s1_vld_q, s1_sign_q, s1_zero_q, s1_rnd_q;
  logic [PW-1:0]    s1_prod_q;
  logic [ESW-1:0]   s1_esum_q;

  // Stage 2 combinational
  logic [LW-1:0]    lead;
  logic [PW-1:0]    norm;
  logic [BEW-1:0]   be, shneed;
  logic             is_sub;
  logic [SHW-1:0]   sh;
  logic [TW-1:0]    t;
  logic [SW-1:0]    kept;
  logic             guard, sticky, inc, sat;
  logic [EXW-1:0]   exm1;
  logic [MGW-1:0]   mag, rnd;
  logic [W-1:0]     data_d;
  logic             sat_d, inx_d;

  // Output registers
  logic             out_valid_q, out_sat_q, out_inexact_q;
  logic [W-1:0]     out_data_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign sig_a  = {(ea != '0), a[MAN_W-1:0]};
  assign sig_b  = {(eb != '0), b[MAN_W-1:0]};
  assign eeff_a = (ea == '0) ? ESW'(1) : ESW'(ea);
  assign eeff_b = (eb == '0) ? ESW'(1) : ESW'(eb);
  assign esum_d = eeff_a + eeff_b - ESW'(2 * BIAS);
  assign prod_d = PW'(sig_a) * PW'(sig_b);
  assign zero_d = (sig_a == '0) || (sig_b == '0);
  assign sign_d = a[W-1] ^ b[W-1];

  always_comb begin
    lead   = '0;
    for (int i = 0; i < PW; i++) begin
      if (s1_prod_q[i]) lead = LW'(i);
    end
    norm   = s1_prod_q << (LW'(PW - 1) - lead);
    be     = {{(BEW-ESW){s1_esum_q[ESW-1]}}, s1_esum_q} + BEW'(lead) + BEW'(BIAS - 2 * MAN_W);
    is_sub = be[BEW-1] || (be == '0);
    shneed = BEW'(1) - be;
    sh     = '0;
    if (is_sub) sh = (shneed > BEW'(PW + 1)) ? SHW'(PW + 1) : shneed[SHW-1:0];
    // Extra low zeros catch every bit shifted out so sticky stays exact.
    t      = {norm, {(PW + 2){1'b0}}} >> sh;
    kept   = t[TW-1 -: SW];
    guard  = t[TW-1-SW];
    sticky = |t[TW-2-SW:0];
    inc    = !s1_rnd_q && guard && (sticky || kept[0]);
    // Hidden bit of kept adds the last exponent step, so a carry renormalises for free.
    exm1   = is_sub ? '0 : EXW'(be - BEW'(1));
    mag    = {exm1, {MAN_W{1'b0}}} + MGW'(kept);
    rnd    = mag + MGW'(inc);
    sat    = rnd[MGW-1:MAN_W] > EXW'(EMAX);

    data_d = {s1_sign_q, rnd[W-2:0]};
    sat_d  = 1'b0;
    inx_d  = guard || sticky;
    if (s1_zero_q) begin
      data_d = {s1_sign_q, {(W-1){1'b0}}};
      inx_d  = 1'b0;
    end else if (sat) begin
      data_d = {s1_sign_q, {(W-1){1'b1}}};
      sat_d  = 1'b1;
      inx_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q      <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_zero_q     <= 1'b0;
      s1_rnd_q      <= 1'b0;
      s1_prod_q     <= '0;
      s1_esum_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sat_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else if (en) begin
      s1_vld_q    <= in_valid;
      s1_sign_q   <= sign_d;
      s1_zero_q   <= zero_d;
      s1_rnd_q    <= rnd_mode;
      s1_prod_q   <= prod_d;
      s1_esum_q   <= esum_d;
      out_valid_q <= s1_vld_q;
      if (s1_vld_q) begin
        out_data_q    <= data_d;
        out_sat_q     <= sat_d;
        out_inexact_q <= inx_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sat     = out_sat_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fpx_mul_pipe.sv
// Scoreboard bench for fpx_mul_pipe: E2M1 directed/backpressure/reset tests and E4M3 random vs a real-valued model.
module tb_fpx_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { int res; int ts; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // E2M1 instance
  logic       rst0, iv0, ir0, rm0, ov0, ordy0, os0, ox0;
  logic [3:0] a0, b0, od0;
  // E4M3 instance
  logic       rst1, iv1, ir1, rm1, ov1, ordy1, os1, ox1;
  logic [7:0] a1, b1, od1;

  fpx_mul_pipe u0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .rnd_mode(rm0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_sat(os0), .out_inexact(ox0)
  );

  fpx_mul_pipe #(.EXP_W(4), .MAN_W(3)) u1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .rnd_mode(rm1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_sat(os1), .out_inexact(ox1)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic real p2(int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Magnitude of an unsigned code; code 2^(e+m) evaluates to the first value past max.
  function automatic real fval(int e, int m, int code);
    int ef   = code >> m;
    int mf   = code & ((1 << m) - 1);
    int bias = (1 << (e - 1)) - 1;
    if (ef == 0) return real'(mf) * p2(1 - bias - m);
    return real'((1 << m) + mf) * p2(ef - bias - m);
  endfunction

  // Reference: exact real product, rounded by searching the representable value ladder.
  function automatic int fp_model(int e, int m, int av, int bv, bit rm);
    int  mb  = 1 << (e + m);
    int  sg  = ((av ^ bv) >> (e + m)) & 1;
    real p   = fval(e, m, av % mb) * fval(e, m, bv % mb);
    int  lo  = 0;
    int  res;
    bit  inx, sat;
    real dl, dh;
    for (int i = 0; i <= mb; i++) if (fval(e, m, i) <= p) lo = i;
    res = lo;
    if (!rm && lo < mb && fval(e, m, lo) != p) begin
      dl = p - fval(e, m, lo);
      dh = fval(e, m, lo + 1) - p;
      if (dh < dl || (dh == dl && (lo % 2) == 1)) res = lo + 1;
    end
    inx = (fval(e, m, res) != p);
    sat = (res == mb);
    if (sat) begin
      res = mb - 1;
      inx = 1'b1;
    end
    return res | (sg << (e + m)) | (int'(inx) << 16) | (int'(sat) << 17);
  endfunction

  function automatic int ev(int d, int x, int s);
    return d | (x << 16) | (s << 17);
  endfunction

  function automatic int expv(int r, int w);
    return (((r >> 17) & 1) << (w + 1)) | (((r >> 16) & 1) << w) | (r & ((1 << w) - 1));
  endfunction

  // Monitor modes: 0 ready=1, 1 random ready, 2 stall burst on first result, 3 ready=0 and unchecked.
  int mode0 = 0, mode1 = 0, stall0 = 0;
  bit lat0 = 1'b0;

  initial begin
    exp_t e;
    int act;
    ordy0 = 1'b1;
    forever begin
      @(negedge clk);
      case (mode0)
        0: ordy0 = 1'b1;
        1: ordy0 = ($urandom_range(0, 3) != 0);
        2: begin
          if (ov0 && stall0 > 0) begin
            ordy0 = 1'b0;
            stall0--;
          end else ordy0 = 1'b1;
        end
        default: ordy0 = 1'b0;
      endcase
      #1;
      if (mode0 != 3 && !rst0 && ov0) begin
        act = int'({os0, ox0, od0});
        if (q0.size() == 0) check("e2m1 unexpected out_valid", int'(ov0), 0);
        else if (ordy0) begin
          e = q0.pop_front();
          check("e2m1 result", act, expv(e.res, 4));
          if (lat0) check("e2m1 latency", cyc - e.ts, 2);
        end else begin
          check("e2m1 held result", act, expv(q0[0].res, 4));
          check("e2m1 in_ready while stalled", int'(ir0), 0);
        end
      end
    end
  end

  initial begin
    exp_t e;
    int act;
    ordy1 = 1'b1;
    forever begin
      @(negedge clk);
      ordy1 = (mode1 == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (!rst1 && ov1) begin
        act = int'({os1, ox1, od1});
        if (q1.size() == 0) check("e4m3 unexpected out_valid", int'(ov1), 0);
        else if (ordy1) begin
          e = q1.pop_front();
          check("e4m3 result", act, expv(e.res, 8));
        end else begin
          check("e4m3 held result", act, expv(q1[0].res, 8));
          check("e4m3 in_ready while stalled", int'(ir1), 0);
        end
      end
    end
  end

  // Expected value < 0 means the operation is not scored (it is meant to be flushed).
  task automatic issue0(input int av, input int bv, input bit rm, input int expd);
    int n = 0;
    @(negedge clk);
    a0 = av[3:0]; b0 = bv[3:0]; rm0 = rm; iv0 = 1'b1;
    #2;
    while (!ir0 && n < 200) begin
      @(negedge clk); #2; n++;
    end
    if (!ir0) check("e2m1 in_ready timeout", int'(ir0), 1);
    else if (expd >= 0) q0.push_back('{res: expd, ts: cyc});
    @(posedge clk); #1 iv0 = 1'b0;
  endtask

  task automatic issue1(input int av, input int bv, input bit rm, input int expd);
    int n = 0;
    @(negedge clk);
    a1 = av[7:0]; b1 = bv[7:0]; rm1 = rm; iv1 = 1'b1;
    #2;
    while (!ir1 && n < 200) begin
      @(negedge clk); #2; n++;
    end
    if (!ir1) check("e4m3 in_ready timeout", int'(ir1), 1);
    else q1.push_back('{res: expd, ts: cyc});
    @(posedge clk); #1 iv1 = 1'b0;
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (q0.size() != 0) check("e2m1 drain", q0.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic drain1();
    int n = 0;
    while (q1.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (q1.size() != 0) check("e4m3 drain", q1.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int av, bv;
    bit rm;
    rst0 = 1'b1; rst1 = 1'b1; iv0 = 1'b0; iv1 = 1'b0;
    a0 = '0; b0 = '0; rm0 = 1'b0; a1 = '0; b1 = '0; rm1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("e2m1 reset out_valid", int'(ov0), 0);
    check("e2m1 reset out_data", int'(od0), 0);
    check("e2m1 reset flags", int'({os0, ox0}), 0);
    check("e2m1 reset in_ready", int'(ir0), 1);
    check("e4m3 reset out_valid", int'(ov1), 0);
    rst0 = 1'b0; rst1 = 1'b0;

    // Back-to-back basics, saturation, subnormals and ties, with latency checked.
    lat0 = 1'b1;
    issue0('h3, 'h3, 1'b0, ev('h4, 1, 0));
    issue0('h5, 'h3, 1'b0, ev('h6, 1, 0));
    issue0('hB, 'h2, 1'b0, ev('hB, 0, 0));
    issue0('h5, 'h5, 1'b0, ev('h7, 1, 1));
    issue0('h7, 'hF, 1'b0, ev('hF, 1, 1));
    issue0('h1, 'h1, 1'b0, ev('h0, 1, 0));
    issue0('h1, 'h3, 1'b0, ev('h2, 1, 0));
    issue0('h1, 'h3, 1'b1, ev('h1, 1, 0));
    issue0('h8, 'h5, 1'b0, ev('h8, 0, 0));
    drain0();
    lat0 = 1'b0;

    // Backpressure: stall three cycles once the first result shows.
    stall0 = 3; mode0 = 2;
    issue0('h2, 'h2, 1'b0, ev('h2, 0, 0));
    issue0('h3, 'h2, 1'b0, ev('h3, 0, 0));
    issue0('h4, 'h2, 1'b0, ev('h4, 0, 0));
    issue0('h6, 'h3, 1'b0, ev('h7, 0, 0));
    drain0();
    mode0 = 0;

    // Reset with two operations in flight; neither may ever emerge.
    mode0 = 3;
    @(negedge clk);
    issue0('h3, 'h3, 1'b0, -1);
    issue0('h5, 'h2, 1'b0, -1);
    @(negedge clk); rst0 = 1'b1;
    @(posedge clk); #1;
    check("e2m1 mid-reset out_valid", int'(ov0), 0);
    check("e2m1 mid-reset out_data", int'(od0), 0);
    check("e2m1 mid-reset flags", int'({os0, ox0}), 0);
    check("e2m1 mid-reset in_ready", int'(ir0), 1);
    rst0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("e2m1 flushed op absent", int'(ov0), 0);
    end
    mode0 = 0;

    // E2M1 random with random backpressure and idle gaps.
    mode0 = 1;
    for (int i = 0; i < 300; i++) begin
      av = $urandom_range(0, 15); bv = $urandom_range(0, 15); rm = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      issue0(av, bv, rm, fp_model(2, 1, av, bv, rm));
    end
    drain0();
    mode0 = 0;

    // E4M3 directed then random.
    issue1('h38, 'h38, 1'b0, ev('h38, 0, 0));
    issue1('h01, 'h38, 1'b0, ev('h01, 0, 0));
    issue1('h7F, 'h7F, 1'b0, ev('h7F, 1, 1));
    drain1();
    mode1 = 1;
    for (int i = 0; i < 10000; i++) begin
      av = $urandom_range(0, 255); bv = $urandom_range(0, 255); rm = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
      issue1(av, bv, rm, fp_model(4, 3, av, bv, rm));
    end
    drain1();
    mode1 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
